uart_tx_out: RTL and testbench

- Serial transmitter at the far end of the CPU's OUT path.
- The OUT instruction presents register A on the bus and pulses the output strobe. This block captures the byte and shifts it out as an 8N1 UART frame.
- It holds ready low until the stop bit has finished, so the control unit can stall OUT until the transfer completes.
- It sits beside the output register on the CPU bus. It is clocked by the CPU clock, before the HLT gating.

---
 rtl/uart_tx_out.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_out.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_out.sv
// -----------------------------------------------------------------------------
// uart_tx_out
// Serial 8N1 transmitter at the far end of the CPU OUT path. The OUT strobe
// (load) captures data_in while ready is high. The byte is sent as:
//   start bit (0), 8 data bits LSB first, 1 stop bit (1).
// Each bit lasts CLKS_PER_BIT clocks. ready stays low until the stop bit is
// ending, so the control unit can stall OUT until the byte is on the wire.
//
// Ports:
//   clk      in   system clock (CPU clock, ahead of HLT gating)
//   rst_n    in   asynchronous active-low reset
//   data_in  in   [7:0] byte to send, sampled only on an accepted load
//   load     in   transmit request, honoured only while ready=1
//   ready    out  idle / able to accept a load
//   busy     out  frame in progress, always ~ready
//   done     out  one-cycle pulse in the final clock of the stop bit
//   tx       out  serial line, idles high
//
// Timing notes:
// - ready and done are raised for the last clock of the stop bit. A load seen
//   in that clock is accepted at the edge that ends the stop bit.
// - As a result, back-to-back frames have no idle gap: the next start bit
//   begins exactly 10*CLKS_PER_BIT clocks after the previous load edge.
// -----------------------------------------------------------------------------
module uart_tx_out #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       load,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       idx_r, idx_s;
    logic [7:0]       shreg_r, shreg_s;
    logic             tx_r, tx_s;
    logic             ready_r, ready_s;
    logic             done_r, done_s;
    logic             busy_r;
    logic             bit_end_s;
    logic             accept_s;

    assign ready = ready_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign tx    = tx_r;

    // Next-state, datapath and registered-output decode for the frame sequencer.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        shreg_s   = shreg_r;
        tx_s      = tx_r;
        bit_end_s = (cnt_r == CNT_LAST);
        accept_s  = load & ready_r;

        case (state_r)
            IDLE: begin
                cnt_s = CNT_ZERO;
                tx_s  = 1'b1;
                if (accept_s) begin
                    shreg_s = data_in;
                    state_s = START;
                    tx_s    = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_s = DATA;
                    cnt_s   = CNT_ZERO;
                    idx_s   = 3'd0;
                    tx_s    = shreg_r[0];
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    cnt_s = CNT_ZERO;
                    if (idx_r != 3'd7) begin
                        idx_s = idx_r + 3'd1;
                        tx_s  = shreg_r[idx_s];
                    end else begin
                        state_s = STOP;
                        tx_s    = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    cnt_s = CNT_ZERO;
                    // ready is already high here, so a pending load chains
                    // straight into the next start bit.
                    if (accept_s) begin
                        shreg_s = data_in;
                        state_s = START;
                        tx_s    = 1'b0;
                    end else begin
                        state_s = IDLE;
                        tx_s    = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
                idx_s   = 3'd0;
                tx_s    = 1'b1;
            end
        endcase

        // The last clock of the stop bit is the done/ready window.
        done_s  = (state_s == STOP) && (cnt_s == CNT_LAST);
        ready_s = (state_s == IDLE) || done_s;
    end

    // State and output registers with asynchronous reset to the idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 3'd0;
            shreg_r <= 8'd0;
            tx_r    <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shreg_r <= shreg_s;
            tx_r    <= tx_s;
            ready_r <= ready_s;
            busy_r  <= ~ready_s;
            done_r  <= done_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_out.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_out
// Self-checking bench for uart_tx_out with CLKS_PER_BIT=4.
//
// Reference model: each frame is tracked only by the number of clock edges
// elapsed since its load edge (t) and its 10-bit image {stop, byte, start}.
// From these:
//   tx    = bit t/N of the image
//   ready = no frame active, or t is the last clock of the frame
//   done  = t is the last clock of the frame
//
// Every cycle, at negedge, the DUT outputs are compared with this model.
// Directed tests additionally pin decoded frames and pulse positions to literal
// expectations. "t" counts the sample taken after the t-th edge following the
// load edge (t=0 is just after the load edge).
// -----------------------------------------------------------------------------
module tb_uart_tx_out;

    localparam int N = 4;
    localparam int F = 10 * N;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       load;
    logic       ready, busy, done, tx;

    int total = 0;
    int bad   = 0;

    uart_tx_out #(.CLKS_PER_BIT(N), .CNT_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .load    (load),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state.
    logic       m_active = 1'b0;
    int         m_t      = 0;
    logic [9:0] m_frame  = 10'h3ff;

    function automatic logic m_ready();
        return !m_active || (m_t == F - 1);
    endfunction

    // Model update on each clock edge, asynchronous reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
        end else if (load && m_ready()) begin
            m_active <= 1'b1;
            m_t      <= 0;
            m_frame  <= {1'b1, data_in, 1'b0};
        end else if (m_active) begin
            if (m_t == F - 1) m_active <= 1'b0;
            m_t <= m_t + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("tx",    32'(tx),    32'(m_active ? m_frame[m_t / N] : 1'b1));
        chk("ready", 32'(ready), 32'(m_ready()));
        chk("busy",  32'(busy),  32'(!m_ready()));
        chk("done",  32'(done),  32'(m_active && (m_t == F - 1)));
    end

    // Called at a negedge after load has been driven. Walks t=0..F-1 and
    // samples each bit mid-period. Optionally, it does two things:
    // - pulses a stray load at t=pulse_at;
    // - presents the next byte at t=F-1 (the done cycle).
    task automatic capture(input logic hold_load, input int pulse_at,
                           input logic do_next, input logic [7:0] next_data,
                           output logic [9:0] bits, output int done_at,
                           output int done_cnt, output int rdy_low);
        bits     = 10'h000;
        done_at  = -1;
        done_cnt = 0;
        rdy_low  = 0;
        for (int t = 0; t < F; t++) begin
            @(negedge clk);
            if (t % N == N / 2) bits[t / N] = tx;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = t;
            end
            if (ready === 1'b0) rdy_low++;
            if (t == 0 && !hold_load) load = 1'b0;
            if (t == pulse_at) begin load = 1'b1; data_in = 8'hFF; end
            if (t == pulse_at + 1) load = 1'b0;
            if (t == F - 1 && do_next) begin load = 1'b1; data_in = next_data; end
        end
    endtask

    logic [9:0] bits;
    int d_at, d_cnt, r_low, w;

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx",    32'(tx),    32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single A5 frame.
        load = 1'b1; data_in = 8'hA5;
        capture(1'b0, -10, 1'b0, 8'h00, bits, d_at, d_cnt, r_low);
        chk("a5_bits",     32'(bits),  32'(10'b1101001010));
        chk("a5_done_at",  32'(d_at),  32'd39);
        chk("a5_done_cnt", 32'(d_cnt), 32'd1);
        chk("a5_rdy_low",  32'(r_low), 32'd39);
        @(negedge clk);

        // Same frame with a stray load of FF mid-frame: must be ignored.
        load = 1'b1; data_in = 8'hA5;
        capture(1'b0, 10, 1'b0, 8'h00, bits, d_at, d_cnt, r_low);
        chk("ign_bits",     32'(bits),  32'(10'b1101001010));
        chk("ign_done_cnt", 32'(d_cnt), 32'd1);
        @(negedge clk);

        // Back-to-back 3C then C3; second start bit at edge 40.
        load = 1'b1; data_in = 8'h3C;
        capture(1'b1, -10, 1'b1, 8'hC3, bits, d_at, d_cnt, r_low);
        chk("b2b_bits1",    32'(bits),  32'({1'b1, 8'h3C, 1'b0}));
        chk("b2b_done1",    32'(d_at),  32'd39);
        capture(1'b0, -10, 1'b0, 8'h00, bits, d_at, d_cnt, r_low);
        chk("b2b_bits2",    32'(bits),  32'({1'b1, 8'hC3, 1'b0}));
        chk("b2b_done2",    32'(d_at + F), 32'd79);
        @(negedge clk);

        // Reset mid-frame, away from any clock edge.
        load = 1'b1; data_in = 8'h0F;
        @(negedge clk);
        load = 1'b0;
        repeat (17) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx",    32'(tx),    32'd1);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_busy",  32'(busy),  32'd0);
        chk("mid_rst_done",  32'(done),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load = 1'b1; data_in = 8'h81;
        capture(1'b0, -10, 1'b0, 8'h00, bits, d_at, d_cnt, r_low);
        chk("post_rst_bits", 32'(bits), 32'(10'b1100000010));
        @(negedge clk);

        // OUT with A=03 issued while a frame is in flight: stall until ready.
        load = 1'b1; data_in = 8'h5A;
        @(negedge clk);
        load = 1'b1; data_in = 8'h03;
        w = 0;
        while (ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("out_stalled", 32'(w > 0),   32'd1);
        chk("out_timeout", 32'(w < 100), 32'd1);
        capture(1'b0, -10, 1'b0, 8'h00, bits, d_at, d_cnt, r_low);
        chk("out_bits", 32'(bits), 32'({1'b1, 8'h03, 1'b0}));
        @(negedge clk);

        // Randomized traffic with occasional loads, data churn and a reset.
        for (int i = 0; i < 3000; i++) begin
            load    = ($urandom_range(0, 5) == 0);
            data_in = 8'($urandom);
            if (i == 1700) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        load = 1'b0;
        repeat (F + 2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
